mem_resp: RTL and testbench
===========================

MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 Parameter: ADDR_W, 32, request and bus address width.
REQ-002 Parameter: WORD_W, 32, request write data and read data width.
REQ-003 Parameter: MEM_COUNT_W, 2, access-size code width; 0 none, 1 byte, 2 half, 3 word.
REQ-004 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 clr_n  in  1  async active-low reset.
REQ-007 i_req_addr  in  ADDR_W  byte address of access (EX-stage ALU result).
REQ-008 i_req_wr_data  in  WORD_W  store data, little-endian byte lanes.
REQ-009 i_req_wr_en  in  1  1 store, 0 load.
REQ-010 i_req_count  in  MEM_COUNT_W  access size; 0 means no request.
REQ-011 o_stall  out  1  pipeline hold while access outstanding.
REQ-012 o_done  out  1  one-cycle pulse: access finished.
REQ-013 o_misalign  out  1  one-cycle pulse: request rejected as misaligned.
REQ-014 o_rd_data  out  WORD_W  load result, zero-extended.
REQ-015 o_bus_addr  out  ADDR_W  byte-wide memory address.
REQ-016 o_bus_wr_data  out  8  byte to write.
REQ-017 o_bus_wr_en  out  1  write strobe.
REQ-018 o_bus_rd_en  out  1  read strobe.
REQ-019 i_bus_rd_data  in  8  read byte, valid in the beat it completes.
REQ-020 i_bus_ready  in  1  beat completes on an edge where a strobe and i_bus_ready are both 1.

Function
REQ-021 States SHALL be IDLE, XFER and DONE.
REQ-022 IDLE with i_req_count!=0 and aligned request: o_stall=1 combinationally; on the edge, latch addr/wr_data/wr_en/count, clear beat counter, go to XFER.
REQ-023 Alignment: half needs addr[0]=0; word needs addr[1:0]=0; byte is always aligned.
REQ-024 IDLE with a misaligned request: o_stall=0, o_misalign=1 that cycle; no bus strobe; no state change.
REQ-025 XFER: o_stall=1; exactly one of o_bus_wr_en/o_bus_rd_en=1 per the latched wr_en; o_bus_addr = latched addr + beat index.
REQ-026 XFER write: o_bus_wr_data = latched wr_data byte lane [beat index].
REQ-027 XFER read: on each completing beat, write i_bus_rd_data into o_rd_data byte lane [beat index].
REQ-028 Beat count SHALL be 1/2/4 for count 1/2/3; the 2-bit beat index increments only on completing beats.
REQ-029 i_bus_ready=0 SHALL hold all bus outputs stable (wait state, unbounded).
REQ-030 Last beat complete -> DONE; in DONE: o_done=1, o_stall=0, strobes 0; next state IDLE unconditionally.
REQ-031 Request inputs SHALL be ignored in XFER and DONE, so a request still present during DONE is not re-accepted.
REQ-032 Load starting the access: o_rd_data SHALL be cleared at acceptance; lanes above the access size stay 0.
REQ-033 Stores SHALL leave o_rd_data unchanged.
REQ-034 Latency: n-byte access with ready held at 1 SHALL take n+2 cycles from acceptance cycle through DONE.
REQ-035 o_bus_addr SHALL wrap modulo 2^ADDR_W.

Reset
REQ-036 clr_n=0 SHALL immediately force IDLE, o_stall=0, o_done=0, o_misalign=0, o_rd_data=0, o_bus_addr=0, o_bus_wr_data=0 and both strobes 0.
REQ-037 Reset mid-XFER SHALL abandon the access with no o_done pulse; the first edge after release samples IDLE.

Verification
REQ-038 Load word: addr 0x100, count 3, ready=1, bytes 0x11,0x22,0x33,0x44 -> rd strobes at 0x100..0x103; o_rd_data=0x44332211; o_done in cycle 6.
REQ-039 Store half: addr 0x202, data 0xAABBCCDD, count 2 -> bus writes 0xDD@0x202, 0xCC@0x203; o_done pulse; o_rd_data unchanged.
REQ-040 Load byte with ready low 3 cycles: addr 0x7, byte 0x80 -> bus outputs stable while waiting; o_rd_data=0x00000080; o_stall high 5 cycles.
REQ-041 Misaligned word at addr 0x102 -> o_misalign=1 for one cycle; o_stall=0; no strobe; stays IDLE.
REQ-042 clr_n low after beat 2 of a word load -> strobes drop asynchronously; no o_done; next word load completes normally.
REQ-043 Back-to-back: byte store then word load presented in the cycle after DONE -> second access accepted; first is not repeated.

Source files
------------

// File: rtl/mem_resp_if.sv
// rtl/mem_resp_if.sv - request, status and byte-bus signals of the memory access responder
interface mem_resp_if #(
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter int MEM_COUNT_W = 2
);
  logic [ADDR_W-1:0]      i_req_addr;
  logic [WORD_W-1:0]      i_req_wr_data;
  logic                   i_req_wr_en;
  logic [MEM_COUNT_W-1:0] i_req_count;
  logic                   o_stall;
  logic                   o_done;
  logic                   o_misalign;
  logic [WORD_W-1:0]      o_rd_data;
  logic [ADDR_W-1:0]      o_bus_addr;
  logic [7:0]             o_bus_wr_data;
  logic                   o_bus_wr_en;
  logic                   o_bus_rd_en;
  logic [7:0]             i_bus_rd_data;
  logic                   i_bus_ready;

  modport slave (
    input  i_req_addr, i_req_wr_data, i_req_wr_en, i_req_count, i_bus_rd_data, i_bus_ready,
    output o_stall, o_done, o_misalign, o_rd_data, o_bus_addr, o_bus_wr_data,
    output o_bus_wr_en, o_bus_rd_en
  );

  modport master (
    output i_req_addr, i_req_wr_data, i_req_wr_en, i_req_count, i_bus_rd_data, i_bus_ready,
    input  o_stall, o_done, o_misalign, o_rd_data, o_bus_addr, o_bus_wr_data,
    input  o_bus_wr_en, o_bus_rd_en
  );
endinterface

// File: rtl/mem_resp.sv
// rtl/mem_resp.sv - splits byte/half/word loads and stores into byte-wide bus beats
module mem_resp #(
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter int MEM_COUNT_W = 2
) (
  input  logic        clk,
  input  logic        clr_n,
  mem_resp_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wr_data;
  logic              r_wr_en;
  logic [1:0]        r_last;
  logic [1:0]        r_beat;
  logic [WORD_W-1:0] r_rd_data;

  logic       w_req;
  logic       w_aligned;
  logic       w_accept;
  logic [1:0] w_last;

  assign w_req = (bus.i_req_count != '0);

  always_comb begin
    w_aligned = 1'b1;
    if (bus.i_req_count == MEM_COUNT_W'(2))
      w_aligned = (bus.i_req_addr[0] == 1'b0);
    else if (bus.i_req_count == MEM_COUNT_W'(3))
      w_aligned = (bus.i_req_addr[1:0] == 2'b00);
  end

  // Last beat index: 0 for byte, 1 for half, 3 for word.
  assign w_last   = (bus.i_req_count == MEM_COUNT_W'(3)) ? 2'd3 :
                    (bus.i_req_count == MEM_COUNT_W'(2)) ? 2'd1 : 2'd0;
  assign w_accept = (r_state == IDLE) && w_req && w_aligned;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
      r_last    <= 2'd0;
      r_beat    <= 2'd0;
      r_rd_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr    <= bus.i_req_addr;
            r_wr_data <= bus.i_req_wr_data;
            r_wr_en   <= bus.i_req_wr_en;
            r_last    <= w_last;
            r_beat    <= 2'd0;
            if (!bus.i_req_wr_en)
              r_rd_data <= '0;
            r_state   <= XFER;
          end
        end
        XFER: begin
          if (bus.i_bus_ready) begin
            if (!r_wr_en)
              r_rd_data[{r_beat, 3'b000} +: 8] <= bus.i_bus_rd_data;
            if (r_beat == r_last)
              r_state <= DONE;
            else
              r_beat <= r_beat + 2'd1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Bus outputs depend only on registers, so a wait state holds them steady.
  assign bus.o_bus_addr    = r_addr + ADDR_W'(r_beat);
  assign bus.o_bus_wr_data = r_wr_data[{r_beat, 3'b000} +: 8];
  assign bus.o_bus_wr_en   = (r_state == XFER) && r_wr_en;
  assign bus.o_bus_rd_en   = (r_state == XFER) && !r_wr_en;
  assign bus.o_rd_data     = r_rd_data;
  assign bus.o_done        = (r_state == DONE);
  assign bus.o_stall       = w_accept || (r_state == XFER);
  assign bus.o_misalign    = (r_state == IDLE) && w_req && !w_aligned;

endmodule

// File: tb/tb_mem_resp.sv
// tb/tb_mem_resp.sv - directed bench for mem_resp
module tb_mem_resp;
  logic clk;
  logic clr_n;
  int   errors;
  int   checks;
  int   stall_cycles;

  mem_resp_if #(.ADDR_W(32), .WORD_W(32), .MEM_COUNT_W(2)) bif ();

  mem_resp #(.ADDR_W(32), .WORD_W(32), .MEM_COUNT_W(2)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic we, input logic [1:0] c);
    bif.i_req_addr    = a;
    bif.i_req_wr_data = d;
    bif.i_req_wr_en   = we;
    bif.i_req_count   = c;
  endtask

  task automatic chk_bus(input string tag, input logic rd, input logic wr, input logic [31:0] a);
    chk({tag, "_rd_en"}, bif.o_bus_rd_en, rd);
    chk({tag, "_wr_en"}, bif.o_bus_wr_en, wr);
    chk({tag, "_addr"},  bif.o_bus_addr, a);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clr_n  = 1'b0;
    req(32'h0, 32'h0, 1'b0, 2'd0);
    bif.i_bus_rd_data = 8'h00;
    bif.i_bus_ready   = 1'b1;

    // Reset state
    #2;
    chk("rst_stall", bif.o_stall, 1'b0);
    chk("rst_done", bif.o_done, 1'b0);
    chk("rst_misalign", bif.o_misalign, 1'b0);
    chk("rst_rd_data", bif.o_rd_data, 32'h0);
    chk("rst_wr_data", bif.o_bus_wr_data, 8'h00);
    chk_bus("rst", 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    clr_n = 1'b1;
    tick();

    // Load word at 0x100
    req(32'h100, 32'h0, 1'b0, 2'd3);
    #1;
    chk("lw_accept_stall", bif.o_stall, 1'b1);
    chk_bus("lw_accept", 1'b0, 1'b0, bif.o_bus_addr);
    tick();
    bif.i_req_count = 2'd0;
    for (int b = 0; b < 4; b++) begin
      bif.i_bus_rd_data = 8'(8'h11 * (b + 1));
      #1;
      chk_bus($sformatf("lw_beat%0d", b), 1'b1, 1'b0, 32'h100 + 32'(b));
      chk($sformatf("lw_beat%0d_stall", b), bif.o_stall, 1'b1);
      tick();
    end
    chk("lw_done", bif.o_done, 1'b1);
    chk("lw_done_stall", bif.o_stall, 1'b0);
    chk("lw_data", bif.o_rd_data, 32'h44332211);
    chk_bus("lw_done", 1'b0, 1'b0, bif.o_bus_addr);
    tick();
    chk("lw_idle_done", bif.o_done, 1'b0);

    // Store half at 0x202
    req(32'h202, 32'hAABBCCDD, 1'b1, 2'd2);
    #1;
    chk("sh_accept_stall", bif.o_stall, 1'b1);
    tick();
    req(32'h0, 32'h0, 1'b0, 2'd0);
    #1;
    chk_bus("sh_beat0", 1'b0, 1'b1, 32'h202);
    chk("sh_beat0_data", bif.o_bus_wr_data, 8'hDD);
    tick();
    chk_bus("sh_beat1", 1'b0, 1'b1, 32'h203);
    chk("sh_beat1_data", bif.o_bus_wr_data, 8'hCC);
    tick();
    chk("sh_done", bif.o_done, 1'b1);
    chk("sh_rd_data_kept", bif.o_rd_data, 32'h44332211);
    tick();

    // Load byte at 0x7 with three wait states
    stall_cycles = 0;
    bif.i_bus_ready = 1'b0;
    req(32'h7, 32'h0, 1'b0, 2'd1);
    #1;
    if (bif.o_stall) stall_cycles++;
    tick();
    bif.i_req_count = 2'd0;
    for (int w = 0; w < 3; w++) begin
      #1;
      if (bif.o_stall) stall_cycles++;
      chk_bus($sformatf("lb_wait%0d", w), 1'b1, 1'b0, 32'h7);
      chk($sformatf("lb_wait%0d_cleared", w), bif.o_rd_data, 32'h0);
      tick();
    end
    bif.i_bus_ready   = 1'b1;
    bif.i_bus_rd_data = 8'h80;
    #1;
    if (bif.o_stall) stall_cycles++;
    chk_bus("lb_beat", 1'b1, 1'b0, 32'h7);
    tick();
    if (bif.o_stall) stall_cycles++;
    chk("lb_done", bif.o_done, 1'b1);
    chk("lb_data", bif.o_rd_data, 32'h00000080);
    chk("lb_stall_cycles", 32'(stall_cycles), 32'd5);
    tick();

    // Misaligned word and half
    req(32'h102, 32'h0, 1'b0, 2'd3);
    #1;
    chk("mis_w_flag", bif.o_misalign, 1'b1);
    chk("mis_w_stall", bif.o_stall, 1'b0);
    chk_bus("mis_w", 1'b0, 1'b0, bif.o_bus_addr);
    tick();
    req(32'h101, 32'h0, 1'b0, 2'd2);
    #1;
    chk("mis_h_flag", bif.o_misalign, 1'b1);
    chk("mis_w_stays_idle", bif.o_bus_rd_en, 1'b0);
    tick();
    bif.i_req_count = 2'd0;
    #1;
    chk("mis_pulse_end", bif.o_misalign, 1'b0);
    chk("mis_idle_stall", bif.o_stall, 1'b0);
    chk("mis_idle_done", bif.o_done, 1'b0);
    tick();

    // Reset during a word load, after two beats
    req(32'h300, 32'h0, 1'b0, 2'd3);
    tick();
    bif.i_req_count = 2'd0;
    tick();
    tick();
    chk_bus("rst_mid_beat2", 1'b1, 1'b0, 32'h302);
    clr_n = 1'b0;
    #1;
    chk_bus("rst_mid", 1'b0, 1'b0, 32'h0);
    chk("rst_mid_stall", bif.o_stall, 1'b0);
    chk("rst_mid_rd_data", bif.o_rd_data, 32'h0);
    tick();
    chk("rst_mid_no_done", bif.o_done, 1'b0);
    clr_n = 1'b1;
    tick();
    chk("rst_after_no_done", bif.o_done, 1'b0);
    req(32'h400, 32'h0, 1'b0, 2'd3);
    tick();
    bif.i_req_count = 2'd0;
    for (int b = 0; b < 4; b++) begin
      bif.i_bus_rd_data = 8'(b + 1);
      tick();
    end
    chk("post_rst_done", bif.o_done, 1'b1);
    chk("post_rst_data", bif.o_rd_data, 32'h04030201);
    tick();

    // Byte store held through DONE, then word load right after
    req(32'h10, 32'h0000005A, 1'b1, 2'd1);
    tick();
    #1;
    chk_bus("bb_store", 1'b0, 1'b1, 32'h10);
    chk("bb_store_data", bif.o_bus_wr_data, 8'h5A);
    tick();
    chk("bb_store_done", bif.o_done, 1'b1);
    chk("bb_done_stall", bif.o_stall, 1'b0);
    tick();
    req(32'h20, 32'h0, 1'b0, 2'd3);
    #1;
    chk("bb_load_accept", bif.o_stall, 1'b1);
    chk("bb_no_repeat_wr", bif.o_bus_wr_en, 1'b0);
    tick();
    bif.i_req_count = 2'd0;
    for (int b = 0; b < 4; b++) begin
      bif.i_bus_rd_data = 8'(8'hA0 + b);
      #1;
      chk_bus($sformatf("bb_load_beat%0d", b), 1'b1, 1'b0, 32'h20 + 32'(b));
      tick();
    end
    chk("bb_load_done", bif.o_done, 1'b1);
    chk("bb_load_data", bif.o_rd_data, 32'hA3A2A1A0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
